// File: rtl/bch_pkg.sv
// bch_pkg
// Shared definitions for the BCH(15,7) t=2 decode controller slice.
// Holds the controller state type and the code geometry constants:
//   BCH_N  codeword length (number of Chien positions)
//   BCH_M  field degree of GF(2^M), also the natural Chien index width
//   BCH_T  designed correction capability
package bch_pkg;

  localparam int BCH_N = 15;
  localparam int BCH_M = 4;
  localparam int BCH_T = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYND,
    ST_CHK,
    ST_BM,
    ST_CHIEN,
    ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/bch_decode_ctrl_if.sv
// bch_decode_ctrl_if
// Codeword stream bundle around the decode controller.
//   in_valid / in_ready / in_cw               received codeword handshake
//   out_valid / out_ready / out_cw / out_fail  decoded result handshake
// Modports:
//   master  upstream producer + downstream consumer side (drives in_*, out_ready)
//   slave   the controller side (drives in_ready, out_valid, out_cw, out_fail)
interface bch_decode_ctrl_if
  import bch_pkg::*;
#(
  parameter int N = BCH_N
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_cw;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_cw;
  logic         out_fail;

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_cw, out_fail
  );

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_cw, out_fail
  );

endinterface

// File: rtl/bch_chien_seq.sv
// bch_chien_seq
// Steps the Chien search over positions 0..N-1, one per cycle, and
// accumulates the error mask and root count from the root indication.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        wipe err_mask / root_cnt ahead of a new codeword
//   start        one-cycle pulse: begin the walk at index 0
//   root         datapath reports lambda(alpha^-idx) == 0 this cycle
//   en           walk in progress (drives chien_en)
//   idx          position under test
//   done         high on the last position of the walk
//   err_mask     one bit per position where a root was found
//   root_cnt     number of roots seen, saturating at BCH_T+1
module bch_chien_seq
  import bch_pkg::*;
#(
  parameter int N     = BCH_N,
  parameter int IDX_W = BCH_M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic             root,
  output logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             done,
  output logic [N-1:0]     err_mask,
  output logic [1:0]       root_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  // One more root than the code can correct is enough to flag failure.
  localparam logic [1:0] ROOT_MAX = 2'(BCH_T + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      idx      <= '0;
      err_mask <= '0;
      root_cnt <= '0;
    end else begin
      if (clear) begin
        err_mask <= '0;
        root_cnt <= '0;
      end
      if (start) begin
        en  <= 1'b1;
        idx <= '0;
      end else if (en) begin
        // The last position is still evaluated on the cycle the walk ends.
        if (root) begin
          err_mask <= err_mask | (N'(1) << idx);
          if (root_cnt != ROOT_MAX) begin
            root_cnt <= root_cnt + 2'd1;
          end
        end
        if (idx == LAST_IDX) begin
          idx <= '0;
          en  <= 1'b0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  assign done = en && (idx == LAST_IDX);

endmodule

// File: rtl/bch_decode_ctrl.sv
// bch_decode_ctrl
// Sequencer for the BCH(15,7) t=2 decode datapath: takes one codeword,
// strobes syndrome capture, runs Berlekamp-Massey for BM_LAT cycles, walks
// the Chien search and returns the corrected codeword or a fail flag.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus          codeword in/out handshakes (bch_decode_ctrl_if.slave)
//   syn_load     one-cycle strobe to compute S1..S3 from cw_q
//   cw_q         registered codeword for the datapath
//   syn_zero     all syndromes zero, sampled in CHK
//   bm_run       BM block enable
//   lam_deg      lambda degree, latched at the end of BM
//   chien_en     Chien evaluation active
//   chien_idx    position under test
//   chien_root   root found at chien_idx
//   busy         controller not idle
// Optional build macro BCH_STATS_EN adds stat_corr / stat_fail counters.
module bch_decode_ctrl
  import bch_pkg::*;
#(
  parameter int N      = BCH_N,
  parameter int BM_LAT = 1,
  parameter int IDX_W  = BCH_M
) (
  input  logic              clk,
  input  logic              rst,
  bch_decode_ctrl_if.slave  bus,
  output logic              syn_load,
  output logic [N-1:0]      cw_q,
  input  logic              syn_zero,
  output logic              bm_run,
  input  logic [1:0]        lam_deg,
  output logic              chien_en,
  output logic [IDX_W-1:0]  chien_idx,
  input  logic              chien_root,
`ifdef BCH_STATS_EN
  output logic [15:0]       stat_corr,
  output logic [15:0]       stat_fail,
`endif
  output logic              busy
);

  localparam int BM_W = (BM_LAT > 1) ? $clog2(BM_LAT) : 1;

  ctrl_state_e     state_q, state_d;
  logic [BM_W-1:0] bm_cnt;
  logic [1:0]      lam_q;
  logic            zero_q;
  logic            chien_clear, chien_start, chien_done;
  logic [N-1:0]    err_mask;
  logic [1:0]      root_cnt;
  logic            fail_raw;

  bch_chien_seq #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_chien (
    .clk      (clk),
    .rst      (rst),
    .clear    (chien_clear),
    .start    (chien_start),
    .root     (chien_root),
    .en       (chien_en),
    .idx      (chien_idx),
    .done     (chien_done),
    .err_mask (err_mask),
    .root_cnt (root_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    syn_load    = 1'b0;
    bm_run      = 1'b0;
    chien_clear = 1'b0;
    chien_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          chien_clear = 1'b1;
          state_d     = ST_SYND;
        end
      end
      ST_SYND: begin
        syn_load = 1'b1;
        state_d  = ST_CHK;
      end
      ST_CHK: begin
        state_d = syn_zero ? ST_DONE : ST_BM;
      end
      ST_BM: begin
        bm_run = 1'b1;
        if (bm_cnt == '0) begin
          chien_start = 1'b1;
          state_d     = ST_CHIEN;
        end
      end
      ST_CHIEN: begin
        if (chien_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-codeword context: captured word, BM down-counter, lambda degree and
  // the zero-syndrome shortcut flag (which must never report failure).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q   <= '0;
      bm_cnt <= '0;
      lam_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            cw_q   <= bus.in_cw;
            lam_q  <= '0;
            zero_q <= 1'b0;
          end
        end
        ST_CHK: begin
          zero_q <= syn_zero;
          bm_cnt <= BM_W'(BM_LAT - 1);
        end
        ST_BM: begin
          if (bm_cnt == '0) lam_q <= lam_deg;
          else              bm_cnt <= bm_cnt - BM_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign fail_raw      = !zero_q && ((root_cnt != lam_q) || (lam_q == 2'd0));
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_fail  = (state_q == ST_DONE) && fail_raw;
  assign bus.out_cw    = fail_raw ? cw_q : (cw_q ^ err_mask);
  assign busy          = (state_q != ST_IDLE);

`ifdef BCH_STATS_EN
  // Counted once per delivered result, on the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_corr <= '0;
      stat_fail <= '0;
    end else if ((state_q == ST_DONE) && bus.out_ready) begin
      if (fail_raw) begin
        if (stat_fail != 16'hFFFF) stat_fail <= stat_fail + 16'd1;
      end else if (err_mask != '0) begin
        if (stat_corr != 16'hFFFF) stat_corr <= stat_corr + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// tb_bch_decode_ctrl
// Directed bench for bch_decode_ctrl. The syndrome / BM / Chien datapath is
// stood in for by per-vector constants: syn_zero, lam_deg and a mask of
// positions where chien_root fires.
module tb_bch_decode_ctrl;
  import bch_pkg::*;

  localparam int N     = 15;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             syn_load;
  logic [N-1:0]     cw_q;
  logic             syn_zero;
  logic             bm_run;
  logic [1:0]       lam_deg;
  logic             chien_en;
  logic [IDX_W-1:0] chien_idx;
  logic             chien_root;
  logic             busy;
`ifdef BCH_STATS_EN
  logic [15:0]      stat_corr;
  logic [15:0]      stat_fail;
`endif

  logic [N-1:0] root_mask;
  int checks = 0;
  int errors = 0;

  bch_decode_ctrl_if #(.N(N)) bus ();

  bch_decode_ctrl #(.N(N), .BM_LAT(1), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .syn_load   (syn_load),
    .cw_q       (cw_q),
    .syn_zero   (syn_zero),
    .bm_run     (bm_run),
    .lam_deg    (lam_deg),
    .chien_en   (chien_en),
    .chien_idx  (chien_idx),
    .chien_root (chien_root),
`ifdef BCH_STATS_EN
    .stat_corr  (stat_corr),
    .stat_fail  (stat_fail),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign chien_root = chien_en && root_mask[chien_idx];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for out_valid; the accept edge counts as cycle 1. Returns 0 on timeout.
  task automatic waitOutValid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = 0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Offers one codeword and checks the result, its latency and fail flag.
  task automatic applyStimulus(input string tag, input logic [N-1:0] cw, input logic szero,
                               input logic [1:0] ldeg, input logic [N-1:0] roots,
                               input logic [N-1:0] exp_cw, input logic exp_fail, input int exp_lat);
    int lat;
    int guard;
    syn_zero  = szero;
    lam_deg   = ldeg;
    root_mask = roots;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_cw    = cw;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    waitOutValid(lat);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_cw"}, 32'(bus.out_cw), 32'(exp_cw));
    checkOutput({tag, "_fail"}, 32'(bus.out_fail), 32'(exp_fail));
    handshake();
    checkOutput({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int guard;
    logic stable;
    logic quiet;
    bus.in_valid  = 1'b0;
    bus.in_cw     = '0;
    bus.out_ready = 1'b0;
    syn_zero      = 1'b0;
    lam_deg       = 2'd0;
    root_mask     = '0;

    repeat (2) @(posedge clk);
    #1;
    // Reset state, sampled while reset is still asserted.
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_fail", 32'(bus.out_fail), 32'd0);
    checkOutput("rst_cw_q", 32'(cw_q), 32'd0);
    checkOutput("rst_strobes", {29'd0, syn_load, bm_run, chien_en}, 32'd0);
    checkOutput("rst_idx", 32'(chien_idx), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero syndrome shortcut, then the main correction cases.
    applyStimulus("zero", 15'h0000, 1'b1, 2'd0, 15'h0000, 15'h0000, 1'b0, 3);
    applyStimulus("single3", 15'h1234, 1'b0, 2'd1, 15'h0008, 15'h123C, 1'b0, 19);
    applyStimulus("double0_14", 15'h2AAA, 1'b0, 2'd2, 15'h4001, 15'h6AAB, 1'b0, 19);
    applyStimulus("miss_root", 15'h0F0F, 1'b0, 2'd2, 15'h0020, 15'h0F0F, 1'b1, 19);
    applyStimulus("deg0", 15'h5555, 1'b0, 2'd0, 15'h0000, 15'h5555, 1'b1, 19);
    applyStimulus("three_roots", 15'h0123, 1'b0, 2'd2, 15'h000E, 15'h0123, 1'b1, 19);

    // Backpressure: result held for 10 cycles while a new word waits upstream.
    syn_zero      = 1'b1;
    lam_deg       = 2'd0;
    root_mask     = '0;
    bus.in_valid  = 1'b1;
    bus.in_cw     = 15'h7FFF;
    @(posedge clk); #1;
    bus.in_cw     = 15'h0A5A;
    waitOutValid(lat);
    checkOutput("bp_lat", lat, 3);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.out_cw !== 15'h7FFF || bus.out_fail !== 1'b0 || bus.in_ready !== 1'b0)
        stable = 1'b0;
    end
    checkOutput("bp_stable", 32'(stable), 32'd1);
    handshake();
    checkOutput("bp_hs_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_hs_cw_q", 32'(cw_q), 32'h7FFF);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("bp_next_busy", 32'(busy), 32'd1);
    checkOutput("bp_next_cw_q", 32'(cw_q), 32'h0A5A);
    waitOutValid(lat);
    checkOutput("bp_next_out", 32'(bus.out_cw), 32'h0A5A);
    handshake();

    // Reset in the middle of the Chien walk.
    syn_zero     = 1'b0;
    lam_deg      = 2'd1;
    root_mask    = 15'h0200;
    bus.in_valid = 1'b1;
    bus.in_cw    = 15'h1111;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!(chien_en && chien_idx == 4'd7) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("mid_reach_idx7", 32'(chien_idx), 32'd7);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_chien", {27'd0, chien_en, chien_idx}, 32'd0);
    checkOutput("mid_rst_cw_q", 32'(cw_q), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid || busy) quiet = 1'b0;
    end
    checkOutput("mid_no_result", 32'(quiet), 32'd1);
    applyStimulus("after_rst", 15'h1111, 1'b0, 2'd1, 15'h0080, 15'h1191, 1'b0, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
